pe_inject_fifo: RTL
===================

// Module: pe_inject_fifo
// PURPOSE
//  Leaf-side traffic source/sink sitting directly upstream of a BFT leaf port
//  (drives pe_interface, consumes interface_pe/resend). Host pushes dest+data
//  words into a FIFO; block formats packets {valid,dest,src,data}, presents
//  them one per cycle, holds/retries while network asserts resend; captures arrivals.
// PARAMETERS
//  num_leaves  16                       leaves in network; AW=$clog2(num_leaves)
//  payload_sz  43                       src field + data; DW=payload_sz-AW
//  p_sz        1+AW+payload_sz (48)     packet width
//  addr        0                        this leaf's address, placed in src field
//  depth       8                        FIFO entries, power of 2, >=2
// PORTS
//  clk           in   1     clock
//  reset         in   1     synchronous, active-high reset
//  in_dest       in   AW    destination leaf of pushed word
//  in_data       in   DW    data field of pushed word
//  in_valid      in   1     push request
//  in_ready      out  1     FIFO not full; push occurs when in_valid&in_ready
//  pe_interface  out  p_sz  packet to network: [p_sz-1] valid, [p_sz-2-:AW] dest,
//                           [p_sz-2-AW-:AW] src(=addr), [DW-1:0] data
//  interface_pe  in   p_sz  packet from network, [p_sz-1] valid
//  resend        in   1     network rejected the packet presented this cycle
//  rx_data       out  p_sz-1 last received packet less valid bit
//  rx_valid      out  1     one-cycle pulse per received packet
//  rx_count      out  16    received-packet count, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset (sync, high): FIFO flushed (count 0, pointers 0), pe_interface=0,
//    rx_data=0, rx_valid=0, rx_count=0, in_ready=0 during reset cycle, 1 after.
//  - FIFO: push on in_valid&in_ready; in_ready=(count<depth), registered-free
//    combinational from count. Pointers wrap mod depth. Push to full is ignored.
//  - Output slot FSM, registered pe_interface:
//    IDLE (valid=0): if FIFO nonempty -> pop head, load packet, go SEND.
//    SEND (valid=1): accepted at edge where resend==0. On accept: FIFO nonempty
//      -> pop+load next (back-to-back, stays SEND); else valid<=0, go IDLE.
//      resend==1 -> hold identical packet, stay SEND (unbounded retries).
//    resend in IDLE is ignored.
//  - Latency: in_valid accepted at edge N -> earliest pe_interface valid at N+2
//    (write N, pop/load N+1). Sustained throughput 1 packet/cycle with no resend.
//  - Simultaneous push+pop: both occur, count unchanged; push to empty FIFO
//    while slot IDLE is not bypassed (2-cycle latency holds).
//  - Push while full and pop same cycle: in_ready already 0, push not taken.
//  - Packet src field always = addr; dest==addr passed unchanged (no filter).
//  - Receive: interface_pe[p_sz-1]==1 at edge -> rx_data<=interface_pe[p_sz-2:0],
//    rx_valid<=1, rx_count<=rx_count+1 (wrap); else rx_valid<=0, rx_data held.
//    1-cycle latency; receive independent of transmit.
//  - Reset mid-SEND: packet and FIFO contents discarded, no partial state kept.
// CONFIGURATION
//  PE_INJECT_STATS_EN defined: adds outputs tx_count[15:0] (packets accepted,
//    i.e. SEND & !resend edges) and retry_count[15:0] (SEND & resend edges),
//    both saturate at 16'hFFFF, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset, push 3 words (dest 5, data 1/2/3), resend=0 -> pe_interface valid
//    cycles N+2..N+4, dest=5, src=addr, data 1,2,3 back-to-back, then valid=0.
//  2 push 1 word, hold resend=1 for 4 cycles while SEND -> same packet held 5
//    cycles total, released when resend=0; retry_count=4, tx_count=1 (STATS_EN).
//  3 push depth+2 words with resend=1 throughout -> in_ready low once 8 queued
//    plus 1 in slot; extra pushes dropped; release resend -> exactly 9 packets, in order.
//  4 interface_pe valid with data 0x1234 for 1 cycle -> rx_valid 1-cycle pulse,
//    rx_data low bits 0x1234, rx_count=1; preload 16'hFFFF, one packet -> 0.
//  5 assert reset while SEND with 3 queued -> next cycle pe_interface=0, in_ready=1,
//    no stale packet emitted after reset released.
//  6 concurrent push/pop every cycle for 100 cycles, random resend -> scoreboard
//    order/data match, no loss or duplication.

Source files
------------

// File: rtl/pe_inject_fifo_if.sv
// Host/network-side bundle for pe_inject_fifo. The statistics counters appear only
// when PE_INJECT_STATS_EN is defined.
interface pe_inject_fifo_if #(
   parameter int AW   = 4,
   parameter int DW   = 39,
   parameter int P_SZ = 48
);
   logic [AW-1:0]   in_dest;
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_ready;
   logic [P_SZ-1:0] pe_interface;
   logic [P_SZ-1:0] interface_pe;
   logic            resend;
   logic [P_SZ-2:0] rx_data;
   logic            rx_valid;
   logic [15:0]     rx_count;
`ifdef PE_INJECT_STATS_EN
   logic [15:0]     tx_count;
   logic [15:0]     retry_count;

   modport master (
      output in_dest, in_data, in_valid, interface_pe, resend,
      input  in_ready, pe_interface, rx_data, rx_valid, rx_count, tx_count, retry_count
   );
   modport slave (
      input  in_dest, in_data, in_valid, interface_pe, resend,
      output in_ready, pe_interface, rx_data, rx_valid, rx_count, tx_count, retry_count
   );
`else
   modport master (
      output in_dest, in_data, in_valid, interface_pe, resend,
      input  in_ready, pe_interface, rx_data, rx_valid, rx_count
   );
   modport slave (
      input  in_dest, in_data, in_valid, interface_pe, resend,
      output in_ready, pe_interface, rx_data, rx_valid, rx_count
   );
`endif
endinterface

// File: rtl/pe_inject_fifo.sv
// Leaf-side packet injector/receiver for a BFT leaf port. Define PE_INJECT_STATS_EN
// to add saturating tx_count/retry_count outputs.
module pe_inject_fifo #(
   parameter int num_leaves = 16,
   parameter int payload_sz = 43,
   parameter int addr       = 0,
   parameter int depth      = 8
) (
   input logic             clk,
   input logic             reset,
   pe_inject_fifo_if.slave bus
);
   localparam int AW   = $clog2(num_leaves);
   localparam int DW   = payload_sz - AW;
   localparam int P_SZ = 1 + AW + payload_sz;
   localparam int PW   = $clog2(depth);
   localparam int EW   = AW + DW;
   localparam logic [AW-1:0] SRC = AW'(addr);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} slot_state_t;

   slot_state_t     state_r;
   logic [EW-1:0]   mem_r [depth];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [PW:0]     count_r;
   logic [P_SZ-1:0] pe_r;
   logic [P_SZ-2:0] rx_data_r;
   logic            rx_valid_r;
   logic [15:0]     rx_count_r;
   logic            in_ready_s;
   logic            push_s;
   logic            pop_s;
   logic            accept_s;
   logic [EW-1:0]   head_s;

   // Stored entry is {dest, data}; the source field is stamped on the way out.
   function automatic logic [P_SZ-1:0] build_packet(input logic [EW-1:0] entry);
      build_packet = {1'b1, entry[EW-1 -: AW], SRC, entry[DW-1:0]};
   endfunction

   // Handshake decode: the slot pops whenever it is empty or its packet is accepted.
   always_comb begin
      in_ready_s = 1'b0;
      if (!reset && (count_r < (PW+1)'(depth))) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
      accept_s = (state_r == SEND) && !bus.resend;
      pop_s    = (count_r != {(PW+1){1'b0}}) && ((state_r == IDLE) || accept_s);
      push_s   = bus.in_valid && in_ready_s;
      head_s   = mem_r[rd_ptr_r];
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.in_dest, bus.in_data};
            wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // Output slot FSM; resend holds the presented packet for as long as it is asserted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         pe_r    <= {P_SZ{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  pe_r    <= build_packet(head_s);
                  state_r <= SEND;
               end
            end
            SEND: begin
               if (accept_s) begin
                  if (pop_s) begin
                     pe_r <= build_packet(head_s);
                  end else begin
                     pe_r    <= {P_SZ{1'b0}};
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               pe_r    <= {P_SZ{1'b0}};
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Receive capture, independent of the transmit path.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_r  <= {(P_SZ-1){1'b0}};
         rx_valid_r <= 1'b0;
         rx_count_r <= 16'd0;
      end else if (bus.interface_pe[P_SZ-1]) begin
         rx_data_r  <= bus.interface_pe[P_SZ-2:0];
         rx_valid_r <= 1'b1;
         rx_count_r <= rx_count_r + 16'd1;
      end else begin
         rx_valid_r <= 1'b0;
      end
   end

`ifdef PE_INJECT_STATS_EN
   logic [15:0] tx_count_r;
   logic [15:0] retry_count_r;

   // Saturating accept/retry counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_count_r    <= 16'd0;
         retry_count_r <= 16'd0;
      end else if (state_r == SEND) begin
         if (!bus.resend && (tx_count_r != 16'hFFFF)) begin
            tx_count_r <= tx_count_r + 16'd1;
         end
         if (bus.resend && (retry_count_r != 16'hFFFF)) begin
            retry_count_r <= retry_count_r + 16'd1;
         end
      end
   end

   assign bus.tx_count    = tx_count_r;
   assign bus.retry_count = retry_count_r;
`endif

   assign bus.in_ready     = in_ready_s;
   assign bus.pe_interface = pe_r;
   assign bus.rx_data      = rx_data_r;
   assign bus.rx_valid     = rx_valid_r;
   assign bus.rx_count     = rx_count_r;
endmodule
